// File: rtl/memory_block_wrapper.sv
// SPI-slave front end for a 256 x 8 single-port RAM. It takes 10-bit frames
// (2-bit command, 8-bit payload) and either latches an address, writes a word, or shifts read data out on MISO.
module memory_block_wrapper #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic MOSI,
    output logic MISO,
    input  logic SS_n,
    input  logic clk,
    input  logic rst_n
);

    typedef enum logic [2:0] {IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, DONE} state_t;

    state_t               state, state_nxt;
    logic                 cmd_hi;
    logic [2:0]           bit_cnt;
    logic [7:0]           shreg;
    logic [7:0]           payload;
    logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
    logic [7:0]           rd_data;
    logic [7:0]           mem [MEM_DEPTH];
    logic                 last_bit, wr_addr_ld, rd_addr_ld, mem_we;

    // The full payload exists only while the 8th payload bit is on MOSI.
    assign payload = {shreg[6:0], MOSI};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        last_bit   = !SS_n && (bit_cnt == 3'd7);
        wr_addr_ld = 1'b0;
        rd_addr_ld = 1'b0;
        mem_we     = 1'b0;
        if (SS_n) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = CMD;
                CMD: begin
                    case ({cmd_hi, MOSI})
                        2'b00:   state_nxt = WR_ADDR;
                        2'b01:   state_nxt = WR_DATA;
                        2'b10:   state_nxt = RD_ADDR;
                        default: state_nxt = RD_DATA;
                    endcase
                end
                WR_ADDR: begin
                    wr_addr_ld = last_bit;
                    if (last_bit) state_nxt = DONE;
                end
                WR_DATA: begin
                    mem_we = last_bit;
                    if (last_bit) state_nxt = DONE;
                end
                RD_ADDR: begin
                    rd_addr_ld = last_bit;
                    if (last_bit) state_nxt = DONE;
                end
                RD_DATA: if (last_bit) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // MISO defaults low each edge; only the read-data shift drives it high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_hi  <= 1'b0;
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
            wr_addr <= '0;
            rd_addr <= '0;
            rd_data <= 8'd0;
            MISO    <= 1'b0;
        end else begin
            rd_data <= mem[rd_addr];
            MISO    <= 1'b0;
            if (wr_addr_ld) wr_addr <= payload[ADDR_SIZE-1:0];
            if (rd_addr_ld) rd_addr <= payload[ADDR_SIZE-1:0];
            if (SS_n) begin
                bit_cnt <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        cmd_hi  <= MOSI;
                        bit_cnt <= 3'd0;
                    end
                    CMD: begin
                        bit_cnt <= 3'd0;
                        // Snapshot the prefetched word so the shift is immune to later writes.
                        if (cmd_hi && MOSI) begin
                            shreg <= rd_data;
                            MISO  <= rd_data[7];
                        end
                    end
                    WR_ADDR, WR_DATA, RD_ADDR: begin
                        shreg   <= payload;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    RD_DATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt != 3'd7) MISO <= shreg[6];
                        shreg <= {shreg[6:0], 1'b0};
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_addr] <= payload;
    end

endmodule

// File: tb/tb_memory_block_wrapper.sv
// Frame-level bench for memory_block_wrapper. A host model drives SPI frames and
// checks MISO read data against a word-level memory model.
module tb_memory_block_wrapper;

    logic clk = 1'b0;
    logic rst_n, MOSI, MISO, SS_n;

    memory_block_wrapper #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .MOSI (MOSI),
        .MISO (MISO),
        .SS_n (SS_n),
        .clk  (clk),
        .rst_n(rst_n)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem_m [256];
    bit         known [256];
    logic [7:0] wr_a, rd_a;
    logic [7:0] last_rx;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One host frame: inputs change on falling edges, MISO sampled on falling edges.
    // nbits < 10 aborts the frame; nbits > 10 appends random trailing bits.
    task automatic frame(input logic [1:0] cmd, input logic [7:0] pl, input int nbits);
        logic [9:0] bits;
        logic [7:0] rx;
        bits = {cmd, pl};
        rx   = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            if (i == 1) chk("miso_edge0", {7'd0, MISO}, 8'd0);
            if (i >= 2 && i <= 9) rx[9-i] = MISO;
            SS_n = 1'b0;
            MOSI = (i < 10) ? bits[9-i] : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        if (nbits >= 10) chk("miso_tail", {7'd0, MISO}, 8'd0);
        SS_n = 1'b1;
        MOSI = 1'($urandom_range(0, 1));
        last_rx = rx;
        if (nbits >= 10) begin
            case (cmd)
                2'b00: wr_a = pl;
                2'b01: begin
                    mem_m[wr_a] = pl;
                    known[wr_a] = 1'b1;
                end
                2'b10: rd_a = pl;
                default: begin
                    if (known[rd_a]) chk("rd_data", rx, mem_m[rd_a]);
                    else             chk("rd_no_x", {7'd0, $isunknown(rx)}, 8'd0);
                end
            endcase
            if (cmd != 2'b11) chk("miso_quiet", rx, 8'd0);
        end
    endtask

    task automatic rd(input logic [7:0] a);
        frame(2'b10, a, 10);
        frame(2'b11, 8'($urandom), $urandom_range(10, 12));
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        frame(2'b00, a, 10);
        frame(2'b01, d, $urandom_range(10, 12));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] c;
        logic [7:0] p;
        int         nb;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        wr_a = 8'd0;
        rd_a = 8'd0;

        rst_n = 1'b0;
        SS_n  = 1'b1;
        MOSI  = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_miso", {7'd0, MISO}, 8'd0);
        rst_n = 1'b1;
        frame(2'b11, 8'h00, 10);

        frame(2'b00, 8'd100, 10);
        frame(2'b01, 8'd11, 10);
        frame(2'b10, 8'd100, 10);
        frame(2'b11, 8'h00, 10);
        chk("basic_0x0B", last_rx, 8'h0B);

        for (int i = 0; i < 100; i++) wr(8'(100 + i), 8'(11 * ((i % 23) + 1)));
        for (int i = 0; i < 100; i++) rd(8'(100 + i));

        wr(8'd254, 8'h77);
        wr(8'd255, 8'hA5);
        frame(2'b01, 8'h5A, 10);
        rd(8'd255);
        chk("addr255", last_rx, 8'h5A);
        rd(8'd254);
        chk("addr254", last_rx, 8'h77);

        // Aborted write-data, then aborted write-address.
        frame(2'b00, 8'd150, 10);
        frame(2'b01, 8'hEE, 5);
        rd(8'd150);
        chk("abort_data", last_rx, 8'd55);
        frame(2'b00, 8'd7, 6);
        frame(2'b01, 8'h99, 10);
        rd(8'd150);
        chk("abort_addr", last_rx, 8'h99);

        for (int n = 0; n < 150; n++) begin
            c  = 2'($urandom_range(0, 3));
            p  = (c[0] == c[1]) ? 8'($urandom) : 8'($urandom_range(100, 199));
            nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 9) : $urandom_range(10, 12);
            frame(c, p, nb);
        end

        // Reset in the middle of a read-data shift.
        wr(8'd50, 8'hFF);
        frame(2'b10, 8'd50, 10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            SS_n = 1'b0;
            MOSI = (i < 2) ? 1'b1 : 1'b0;
        end
        @(negedge clk);
        chk("pre_reset_miso", {7'd0, MISO}, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_miso", {7'd0, MISO}, 8'd0);
        SS_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr_a = 8'd0;
        rd_a = 8'd0;
        frame(2'b01, 8'h3C, 10);
        frame(2'b11, 8'h00, 10);
        chk("addr_reset", last_rx, 8'h3C);
        rd(8'd50);
        chk("after_reset", last_rx, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
